// File: rtl/pod_uart_responder.sv
// pod_uart_responder
//
// Pod-side end of the logic pod management UART. Receives 5-byte command
// frames (A5, opcode, addr, data, csum) from the host, executes register
// reads/writes against a 16 x 8-bit configuration register file, and sends
// a 5-byte response frame (5A, status, addr, data, csum) for every
// well-formed command.
//
// Optional feature macro: POD_UART_TIMEOUT_EN
//   defined   : an idle gap of more than TIMEOUT_BITS bit times between
//               bytes of one frame abandons the frame (back to HUNT, no
//               response, err_count untouched).
//   undefined : no timeout logic; a partial frame waits indefinitely.
//
// Parameters:
//   BAUD_DIV     clocks per UART bit (>= 16)
//   TIMEOUT_BITS inter-byte idle limit in bit times (timeout build only)
//
// Ports:
//   clk_125mhz   sole clock
//   rst          synchronous reset, active high
//   uart_rx      asynchronous serial input, idle high
//   uart_tx      serial output, idle high
//   reg_wr_en    single-cycle write strobe (high in the EXEC cycle)
//   reg_wr_addr  write address, valid with reg_wr_en
//   reg_wr_data  write data, valid with reg_wr_en
//   regs_out     register file, register n at bits [8n+7:8n]
//   err_count    saturating count of rejected frames

module pod_uart_responder #(
    parameter int BAUD_DIV     = 1085,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         clk_125mhz,
    input  logic         rst,
    input  logic         uart_rx,
    output logic         uart_tx,
    output logic         reg_wr_en,
    output logic [3:0]   reg_wr_addr,
    output logic [7:0]   reg_wr_data,
    output logic [127:0] regs_out,
    output logic [7:0]   err_count
);

    if (BAUD_DIV < 16) begin : g_bad_baud
        $error("BAUD_DIV must be at least 16");
    end
    if (TIMEOUT_BITS < 1) begin : g_bad_timeout
        $error("TIMEOUT_BITS must be at least 1");
    end

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

    localparam logic [7:0] SYNC_CMD  = 8'hA5;
    localparam logic [7:0] SYNC_RESP = 8'h5A;
    localparam logic [7:0] OP_READ   = 8'h01;
    localparam logic [7:0] OP_WRITE  = 8'h02;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_CSUM   = 8'h01;
    localparam logic [7:0] ST_OPCODE = 8'h02;
    localparam logic [7:0] ST_ADDR   = 8'h03;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_HUNT,
        S_OPCODE,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_EXEC,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    // rx_s3_q is the previous synchronized sample, used for edge detection
    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_valid_q, rx_valid_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == BAUD_HALF) begin
                    // line back high at mid start bit: treat as a glitch
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_state_d = RX_IDLE;
                    // a low stop bit drops the byte silently
                    rx_valid_d = rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
        end
        rx_sh_q <= rx_sh_d;
    end

    // ------------------------------------------------------------------
    // Frame parser, executor and transmitter
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    regs_q [16];
    logic [7:0]    regs_d [16];
    logic [7:0]    err_q, err_d;
    logic          tx_q, tx_d;
    logic [39:0]   tx_buf_q, tx_buf_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [2:0]    tx_byte_q, tx_byte_d;
    logic          wr_en_c;

    logic [7:0]    status_c;
    logic [7:0]    resp_data_c;
    logic [7:0]    tx_cur_c;

`ifdef POD_UART_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS * BAUD_DIV);
    logic [31:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        status_c = ST_OK;
        if ((op_q ^ addr_q ^ data_q) != csum_q) begin
            status_c = ST_CSUM;
        end else if (op_q != OP_READ && op_q != OP_WRITE) begin
            status_c = ST_OPCODE;
        end else if (addr_q[7:4] != 4'h0) begin
            status_c = ST_ADDR;
        end
    end

    // write data is returned directly so the response shows the new value
    always_comb begin
        resp_data_c = 8'h00;
        if (status_c == ST_OK) begin
            resp_data_c = (op_q == OP_WRITE) ? data_q : regs_q[addr_q[3:0]];
        end
    end

    assign tx_cur_c = tx_buf_q[{tx_byte_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        csum_d    = csum_q;
        regs_d    = regs_q;
        err_d     = err_q;
        tx_d      = tx_q;
        tx_buf_d  = tx_buf_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_byte_d = tx_byte_q;
        wr_en_c   = 1'b0;
`ifdef POD_UART_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        case (state_q)
            S_HUNT: begin
                if (rx_valid_q && rx_sh_q == SYNC_CMD) state_d = S_OPCODE;
            end
            S_OPCODE: begin
                if (rx_valid_q) begin
                    op_d    = rx_sh_q;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid_q) begin
                    addr_d  = rx_sh_q;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid_q) begin
                    data_d  = rx_sh_q;
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_valid_q) begin
                    csum_d  = rx_sh_q;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (status_c == ST_OK) begin
                    if (op_q == OP_WRITE) begin
                        regs_d[addr_q[3:0]] = data_q;
                        wr_en_c             = 1'b1;
                    end
                end else if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
                tx_buf_d  = {status_c ^ addr_q ^ resp_data_c, resp_data_c,
                             addr_q, status_c, SYNC_RESP};
                tx_d      = 1'b0;
                tx_cnt_d  = '0;
                tx_bit_d  = '0;
                tx_byte_d = '0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                // tx_bit_q: 0 = start, 1..8 = data LSB first, 9 = stop
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_byte_q == 3'd4) begin
                            tx_d    = 1'b1;
                            state_d = S_HUNT;
                        end else begin
                            tx_byte_d = tx_byte_q + 3'd1;
                            tx_bit_d  = '0;
                            tx_d      = 1'b0;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : tx_cur_c[tx_bit_q[2:0]];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: state_d = S_HUNT;
        endcase

`ifdef POD_UART_TIMEOUT_EN
        // counts idle cycles since the last stop-bit sample inside a frame
        if ((state_q == S_OPCODE || state_q == S_ADDR || state_q == S_DATA ||
             state_q == S_CSUM) && rx_state_q == RX_IDLE && !rx_valid_q) begin
            if (to_cnt_q == TO_LIMIT) begin
                state_d = S_HUNT;
            end else begin
                to_cnt_d = to_cnt_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            state_q   <= S_HUNT;
            err_q     <= '0;
            tx_q      <= 1'b1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_byte_q <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            tx_q      <= tx_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_byte_q <= tx_byte_d;
            regs_q    <= regs_d;
        end
        op_q     <= op_d;
        addr_q   <= addr_d;
        data_q   <= data_d;
        csum_q   <= csum_d;
        tx_buf_q <= tx_buf_d;
    end

`ifdef POD_UART_TIMEOUT_EN
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    always_comb begin
        regs_out = '0;
        for (int n = 0; n < 16; n++) regs_out[8*n +: 8] = regs_q[n];
    end

    assign uart_tx     = tx_q;
    assign reg_wr_en   = wr_en_c;
    assign reg_wr_addr = wr_en_c ? addr_q[3:0] : 4'h0;
    assign reg_wr_data = wr_en_c ? data_q : 8'h00;
    assign err_count   = err_q;

endmodule
